fetch_decode_skid_buffer: RTL and testbench

FETCH_DECODE_SKID_BUFFER -- requirements
Module: fetch_decode_skid_buffer

---
 rtl/fd_pipe_pkg.sv | 8 +
 rtl/fetch_decode_skid_buffer.sv | 64 ++++++
 tb/tb_fetch_decode_skid_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fd_pipe_pkg.sv
// fd_pipe_pkg: shared bubble constant and entry layout for the fetch/decode buffer.
package fd_pipe_pkg;
   localparam logic [31:0] FD_NOP_INSTR = 32'h00000013;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instruction;
   } fd_entry_t;
endpackage

// File: rtl/fetch_decode_skid_buffer.sv
// fetch_decode_skid_buffer: circular FIFO between fetch and decode with flush and stall counting.
module fetch_decode_skid_buffer
   import fd_pipe_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ILEN = 32,
   parameter int DEPTH = 2,
   parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(FD_NOP_INSTR)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [XLEN-1:0]            pc_in,
   input  logic [ILEN-1:0]            instruction_in,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            pc_out,
   output logic [ILEN-1:0]            instruction_out,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [31:0]                stall_cycles
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instruction;
   } entry_t;
   entry_t mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [31:0] stall_cnt;
   logic push, pop;
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
   endfunction
   // Handshake flags depend only on registered count, so out_ready never reaches in_ready.
   assign in_ready        = count < CW'(DEPTH);
   assign out_valid       = count != '0;
   assign push            = in_valid & in_ready & ~flush;
   assign pop             = out_valid & out_ready & ~flush;
   assign occupancy       = count;
   assign stall_cycles    = stall_cnt;
   assign pc_out          = out_valid ? mem[rd_ptr].pc : '0;
   assign instruction_out = out_valid ? mem[rd_ptr].instruction : NOP_INSTR;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= '{pc: pc_in, instruction: instruction_in};
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop) rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) stall_cnt <= '0;
      else if (out_valid && !out_ready && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
   end
endmodule

// File: tb/tb_fetch_decode_skid_buffer.sv
// tb_fetch_decode_skid_buffer: directed stimulus with scoreboard queues checked by negedge monitors.
module tb_fetch_decode_skid_buffer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   logic a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
   logic [31:0] a_pc_in, a_instr_in, a_pc_out, a_instr_out, a_stall;
   logic [1:0] a_occ;
   logic b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
   logic [31:0] b_pc_in, b_instr_in, b_pc_out, b_instr_out, b_stall;
   logic [2:0] b_occ;
   int checks = 0;
   int failures = 0;
   int b_pops = 0;
   logic [63:0] qa[$];
   logic [63:0] qb[$];

   fetch_decode_skid_buffer #(.DEPTH(2)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .pc_in(a_pc_in),
      .instruction_in(a_instr_in), .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .pc_out(a_pc_out), .instruction_out(a_instr_out), .occupancy(a_occ), .stall_cycles(a_stall));
   fetch_decode_skid_buffer #(.DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .pc_in(b_pc_in),
      .instruction_in(b_instr_in), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .pc_out(b_pc_out), .instruction_out(b_instr_out), .occupancy(b_occ), .stall_cycles(b_stall));

   function automatic logic [31:0] ins(input logic [31:0] pc);
      return {pc[19:0], 12'h093};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_push(input logic [31:0] pc);
      a_in_valid = 1'b1;
      a_pc_in = pc;
      a_instr_in = ins(pc);
      if (a_in_ready && !a_flush) qa.push_back({pc, ins(pc)});
   endtask

   always @(negedge clk) begin
      if (rst && a_out_valid && a_out_ready && !a_flush) begin
         if (qa.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_pop actual=%h required=none", a_pc_out);
         end else chk("a_pop", {a_pc_out, a_instr_out}, qa.pop_front());
      end
      if (rst && b_out_valid && b_out_ready && !b_flush) begin
         b_pops++;
         if (qb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_pop actual=%h required=none", b_pc_out);
         end else chk("b_pop", {b_pc_out, b_instr_out}, qb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      {a_in_valid, a_flush, a_out_ready, b_in_valid, b_flush, b_out_ready} = '0;
      {a_pc_in, a_instr_in, b_pc_in, b_instr_in} = '0;
      a_in_valid = 1'b1;
      b_in_valid = 1'b1;
      step();
      step();
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_instr", a_instr_out, 32'h00000013);
      chk("rst_pc", a_pc_out, 0);
      chk("rst_occ", a_occ, 0);
      chk("rst_stall", a_stall, 0);
      chk("rst_b_occ", b_occ, 0);
      rst = 1'b1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      step();
      // Streaming: each pair must be on the outputs one cycle after its push.
      a_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_push(32'(i * 4));
         step();
         chk("stream_occ", a_occ, 1);
         chk("stream_pc", a_pc_out, 32'(i * 4));
      end
      a_in_valid = 1'b0;
      step();
      chk("stream_drain_occ", a_occ, 0);
      chk("stream_stall", a_stall, 0);
      // Backpressure on DEPTH=2.
      a_out_ready = 1'b0;
      a_push(32'h100);
      step();
      chk("bp_occ1", a_occ, 1);
      chk("bp_stall0", a_stall, 0);
      a_push(32'h104);
      step();
      chk("bp_occ2", a_occ, 2);
      chk("bp_stall1", a_stall, 1);
      a_push(32'h108);
      chk("bp_full_ready", a_in_ready, 0);
      step();
      chk("bp_occ_full", a_occ, 2);
      chk("bp_stall2", a_stall, 2);
      chk("bp_head", a_pc_out, 32'h100);
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      step();
      chk("bp_rel_occ", a_occ, 1);
      chk("bp_rel_pc", a_pc_out, 32'h104);
      step();
      chk("bp_empty_occ", a_occ, 0);
      chk("bp_stall_hold", a_stall, 2);
      // Flush with a full buffer and a presented pair.
      a_out_ready = 1'b0;
      a_push(32'h180);
      step();
      a_push(32'h184);
      step();
      chk("fl_pre_occ", a_occ, 2);
      a_flush = 1'b1;
      a_push(32'h200);
      qa.delete();
      step();
      chk("fl_occ", a_occ, 0);
      chk("fl_out_valid", a_out_valid, 0);
      chk("fl_instr", a_instr_out, 32'h00000013);
      chk("fl_pc", a_pc_out, 0);
      chk("fl_stall", a_stall, 3);
      // Flush must also discard a push that would otherwise be accepted.
      a_flush = 1'b0;
      a_push(32'h210);
      step();
      chk("fl1_pre_occ", a_occ, 1);
      a_flush = 1'b1;
      a_push(32'h220);
      qa.delete();
      step();
      chk("fl1_occ", a_occ, 0);
      a_flush = 1'b0;
      a_out_ready = 1'b1;
      a_push(32'h300);
      step();
      chk("fl_after_pc", a_pc_out, 32'h300);
      a_in_valid = 1'b0;
      step();
      chk("fl_after_occ", a_occ, 0);
      // Saturation via backdoor preload of the stall counter.
      a_out_ready = 1'b0;
      a_push(32'h400);
      step();
      a_in_valid = 1'b0;
      @(negedge clk);
      force dut_a.stall_cnt = 32'hFFFFFFFE;
      #1;
      release dut_a.stall_cnt;
      step();
      chk("sat_first", a_stall, 32'hFFFFFFFF);
      step();
      step();
      chk("sat_hold", a_stall, 32'hFFFFFFFF);
      // Reset mid-operation beats flush, push and pop.
      a_flush = 1'b1;
      a_out_ready = 1'b1;
      a_in_valid = 1'b1;
      a_pc_in = 32'h404;
      rst = 1'b0;
      qa.delete();
      step();
      chk("mrst_occ", a_occ, 0);
      chk("mrst_stall", a_stall, 0);
      chk("mrst_valid", a_out_valid, 0);
      chk("mrst_ready", a_in_ready, 1);
      rst = 1'b1;
      a_flush = 1'b0;
      a_in_valid = 1'b0;
      step();
      chk("mrst_after_occ", a_occ, 0);
      // Wrap-around on DEPTH=4 with alternating out_ready.
      b_out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         int tries;
         tries = 0;
         b_in_valid = 1'b1;
         b_pc_in = 32'h1000 + 32'(i * 4);
         b_instr_in = ins(b_pc_in);
         while (!b_in_ready && tries < 20) begin
            b_out_ready = ~b_out_ready;
            step();
            tries++;
         end
         if (tries >= 20) begin
            checks++;
            failures++;
            $display("FAIL wrap_accept_timeout actual=stuck required=in_ready");
         end
         qb.push_back({b_pc_in, b_instr_in});
         b_out_ready = ~b_out_ready;
         step();
      end
      b_in_valid = 1'b0;
      b_out_ready = 1'b1;
      repeat (8) step();
      chk("wrap_occ", b_occ, 0);
      chk("wrap_left", qb.size(), 0);
      chk("wrap_pops", b_pops, 10);
      chk("a_left", qa.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
